// File: rtl/pong_match_ctl.sv
// Match-level sequencer for the pong ball controller: menu, serve countdown,
// arming, rally, point-hold and game-over phases, all outputs registered.
module pong_match_ctl #(
  parameter logic [23:0] TICKS     = 24'd6_500_000,
  parameter logic [1:0]  STEPS     = 2'd3,
  parameter logic [23:0] HOLD      = 24'd13_000_000,
  parameter logic [1:0]  WIN_SCORE = 2'd3
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       mouse_left,
  input  logic       button_in,
  input  logic [1:0] score_p1,
  input  logic [1:0] score_p2,
  output logic       ball_start,
  output logic       ball_reset,
  output logic [1:0] countdown,
  output logic [2:0] state_out,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_COUNT = 3'd1,
    ST_ARMED = 3'd2,
    ST_RALLY = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] tick_q, tick_d;
  logic [1:0]  countdown_q, countdown_d;
  logic        ball_start_q, ball_start_d;
  logic        ball_reset_q, ball_reset_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic        mouse_left_q;
  logic        button_q;
  logic [1:0]  s1_q, s2_q;

  logic ml_rise;
  logic pt;

  assign ml_rise = mouse_left & ~mouse_left_q;
  assign pt      = (score_p1 != s1_q) | (score_p2 != s2_q);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_MENU;
      tick_q       <= 24'd0;
      countdown_q  <= 2'd0;
      ball_start_q <= 1'b0;
      ball_reset_q <= 1'b0;
      winner_q     <= 2'd0;
      game_over_q  <= 1'b0;
      mouse_left_q <= 1'b0;
      button_q     <= 1'b0;
      s1_q         <= 2'd0;
      s2_q         <= 2'd0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      countdown_q  <= countdown_d;
      ball_start_q <= ball_start_d;
      ball_reset_q <= ball_reset_d;
      winner_q     <= winner_d;
      game_over_q  <= game_over_d;
      mouse_left_q <= mouse_left;
      button_q     <= button_in;
      s1_q         <= score_p1;
      s2_q         <= score_p2;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    countdown_d  = countdown_q;
    ball_start_d = ball_start_q;
    ball_reset_d = 1'b0;
    winner_d     = winner_q;
    game_over_d  = game_over_q;

    if (button_in) begin
      // Abort wins over everything; the reset pulse fires only on the press edge.
      state_d      = ST_MENU;
      tick_d       = 24'd0;
      countdown_d  = 2'd0;
      ball_start_d = 1'b0;
      ball_reset_d = ~button_q;
      winner_d     = 2'd0;
      game_over_d  = 1'b0;
    end else begin
      case (state_q)
        ST_MENU: begin
          ball_start_d = 1'b0;
          if (ml_rise) begin
            state_d     = ST_COUNT;
            countdown_d = STEPS;
            tick_d      = 24'd0;
          end
        end
        ST_COUNT: begin
          ball_start_d = 1'b0;
          if (tick_q == TICKS - 24'd1) begin
            tick_d = 24'd0;
            if (countdown_q <= 2'd1) begin
              countdown_d  = 2'd0;
              state_d      = ST_ARMED;
              ball_start_d = 1'b1;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        ST_ARMED: begin
          // Level-sensitive serve, mirroring the ball controller's own test.
          ball_start_d = 1'b1;
          if (mouse_left) begin
            state_d = ST_RALLY;
          end
        end
        ST_RALLY: begin
          ball_start_d = 1'b1;
          if (pt) begin
            state_d      = ST_POINT;
            ball_start_d = 1'b0;
            tick_d       = 24'd0;
          end
        end
        ST_POINT: begin
          ball_start_d = 1'b0;
          if (tick_q == HOLD - 24'd1) begin
            tick_d = 24'd0;
            if (score_p1 >= WIN_SCORE) begin
              state_d     = ST_OVER;
              winner_d    = 2'b01;
              game_over_d = 1'b1;
            end else if (score_p2 >= WIN_SCORE) begin
              state_d     = ST_OVER;
              winner_d    = 2'b10;
              game_over_d = 1'b1;
            end else begin
              state_d     = ST_COUNT;
              countdown_d = STEPS;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        ST_OVER: begin
          ball_start_d = 1'b0;
          game_over_d  = 1'b1;
          if (ml_rise) begin
            state_d      = ST_MENU;
            ball_reset_d = 1'b1;
            winner_d     = 2'd0;
            game_over_d  = 1'b0;
          end
        end
        default: begin
          state_d      = ST_MENU;
          tick_d       = 24'd0;
          countdown_d  = 2'd0;
          ball_start_d = 1'b0;
          winner_d     = 2'd0;
          game_over_d  = 1'b0;
        end
      endcase
    end
  end

  assign ball_start = ball_start_q;
  assign ball_reset = ball_reset_q;
  assign countdown  = countdown_q;
  assign state_out  = state_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule
